// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Front-end fetch controller for the dual-slot pipeline. Owns the fetch PC,
// issues one 64-bit instruction-memory request at a time, holds the returned
// doubleword in a one-entry bundle buffer that feeds the static branch
// predictor, and hands decode a two-slot bundle with per-slot valid bits.
// The next fetch PC comes from (highest priority first) an execute-stage
// redirect, a predicted-taken target, or the sequential doubleword.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   mem_req/mem_addr         fetch request and doubleword-aligned address
//   mem_ready/mem_rdata      response strobe and data (slot0 = low word)
//   pred_instr_low/high      buffered slot words to the predictor
//   pred_pc/pred_pc2         buffered bundle base and "slot0 not in bundle"
//   pred_take/target/skip_b  predictor decision for the buffered bundle
//   redirect_valid/pc        execute-stage PC correction
//   out_valid/out_ready      bundle handshake with decode
//   out_pc, out_instr_*      bundle base address and slot words
//   out_low/high_valid       per-slot architectural liveness
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,

    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [63:0] mem_rdata,

    output logic [31:0] pred_instr_low,
    output logic [31:0] pred_instr_high,
    output logic [31:0] pred_pc,
    output logic        pred_pc2,
    input  logic        pred_take,
    input  logic [31:0] pred_target,
    input  logic        pred_skip_b,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr_low,
    output logic [31:0] out_instr_high,
    output logic        out_low_valid,
    output logic        out_high_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding for pc (once armed)
        HOLD  = 2'd1,   // bundle buffered, offered to decode
        DRAIN = 2'd2    // request outstanding, its data is stale
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] bpc, bpc_nxt;
    logic [31:0] buf_low, buf_low_nxt;
    logic [31:0] buf_high, buf_high_nxt;

    // Clear during reset and the cycle reset deasserts, so the first request
    // appears one cycle after reset is sampled low.
    logic        armed;

    logic        req_active;
    logic        resp;
    logic [31:0] redirect_aligned;
    logic [31:0] bundle_base;
    logic [31:0] seq_pc;

    assign req_active       = armed && (state != HOLD);
    assign resp             = req_active && mem_ready;
    assign redirect_aligned = redirect_pc & ~32'h3;
    assign bundle_base      = bpc & ~32'h7;
    assign seq_pc           = bundle_base + 32'd8;   // wraps modulo 2^32

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational process.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            bpc      <= 32'h0;
            // NOTE: the bundle buffer is a plain register pair, not a memory
            // array, so it is cleared here to give decode and the predictor
            // defined values straight out of reset.
            buf_low  <= 32'h0;
            buf_high <= 32'h0;
            armed    <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            bpc      <= bpc_nxt;
            buf_low  <= buf_low_nxt;
            buf_high <= buf_high_nxt;
            armed    <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    // NOTE: every variable written below gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        bpc_nxt        = bpc;
        buf_low_nxt    = buf_low;
        buf_high_nxt   = buf_high;
        mem_req        = req_active;
        out_valid      = 1'b0;
        out_low_valid  = 1'b0;
        out_high_valid = 1'b0;

        unique case (state)
            FETCH: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_aligned;
                    // A request already on the bus cannot be aborted; wait
                    // out its response unless it is arriving right now.
                    if (req_active && !mem_ready) state_nxt = DRAIN;
                end else if (resp) begin
                    buf_low_nxt  = mem_rdata[31:0];
                    buf_high_nxt = mem_rdata[63:32];
                    bpc_nxt      = pc;
                    state_nxt    = HOLD;
                end
            end

            HOLD: begin
                out_valid      = !redirect_valid;
                out_low_valid  = !bpc[2];
                out_high_valid = !(pred_take && pred_skip_b);
                if (redirect_valid) begin
                    pc_nxt    = redirect_aligned;
                    state_nxt = FETCH;
                end else if (out_ready) begin
                    pc_nxt    = pred_take ? pred_target : seq_pc;
                    state_nxt = FETCH;
                end
            end

            DRAIN: begin
                if (redirect_valid) pc_nxt = redirect_aligned;
                // The stale response ends the drain even if a newer redirect
                // lands in the same cycle; pc already holds the latest target.
                if (resp) state_nxt = FETCH;
            end

            default: state_nxt = FETCH;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered-only outputs
    // -------------------------------------------------------------------------
    assign mem_addr        = pc & ~32'h7;
    assign pred_instr_low  = buf_low;
    assign pred_instr_high = buf_high;
    assign pred_pc         = bundle_base;
    assign pred_pc2        = bpc[2];
    assign out_pc          = bundle_base;
    assign out_instr_low   = buf_low;
    assign out_instr_high  = buf_high;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed walk-through of reset, sequential fetch, slot0/slot1 predicted
// branches, draining redirects, backpressure, coincident redirect/response,
// mid-fetch reset and address wrap, followed by a randomized phase. In the
// random phase, issuing a redirect pushes the expected bundle into a queue;
// a monitor pops and compares on every accepted bundle and pushes the
// architecturally next bundle, derived from a program-image model.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic [31:0] pred_instr_low;
    logic [31:0] pred_instr_high;
    logic [31:0] pred_pc;
    logic        pred_pc2;
    logic        pred_take;
    logic [31:0] pred_target;
    logic        pred_skip_b;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr_low;
    logic [31:0] out_instr_high;
    logic        out_low_valid;
    logic        out_high_valid;

    fetch_sequencer #(.RESET_PC(32'h0000_1000)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata),
        .pred_instr_low  (pred_instr_low),
        .pred_instr_high (pred_instr_high),
        .pred_pc         (pred_pc),
        .pred_pc2        (pred_pc2),
        .pred_take       (pred_take),
        .pred_target     (pred_target),
        .pred_skip_b     (pred_skip_b),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr_low   (out_instr_low),
        .out_instr_high  (out_instr_high),
        .out_low_valid   (out_low_valid),
        .out_high_valid  (out_high_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int accepts    = 0;
    logic scoreboard_on = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] low;
        logic [31:0] high;
        logic        low_live;
        logic        high_live;
        logic [31:0] next_pc;
    } bundle_t;

    bundle_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction encoding shared by predictor and model ----
    function automatic logic is_back_branch(input logic [31:0] w);
        return (w[6:0] == 7'h63) && w[31];
    endfunction

    function automatic logic [31:0] br_off(input logic [31:0] w);
        return {{20{w[31]}}, w[31:22], 2'b00};
    endfunction

    function automatic logic [31:0] make_br(input logic [31:0] off);
        return {off[11:2], 15'h0, 7'h63};
    endfunction

    // Program image: a pseudo-random word per address, ~3/16 backward branches.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        h = (a ^ 32'h5bd1_e995) * 32'h9e37_79b1;
        h = h ^ (h >> 15);
        if (h[3:0] < 4'd3) return {1'b1, h[12:4], h[27:13], 7'h63};
        return {h[31:7], 7'h13};
    endfunction

    // Architectural view of a bundle fetched for pc: walk the live slots in
    // program order; the first backward branch redirects the stream and kills
    // anything after it in the same doubleword.
    function automatic bundle_t ref_bundle(input logic [31:0] pc);
        bundle_t     b;
        logic [31:0] base;
        logic [31:0] w;
        logic        done;
        base        = pc & ~32'h7;
        b.pc        = base;
        b.low       = mem_word(base);
        b.high      = mem_word(base + 32'd4);
        b.low_live  = !pc[2];
        b.high_live = 1'b1;
        b.next_pc   = base + 32'd8;
        done        = 1'b0;
        for (int s = 0; s < 2; s++) begin
            w = (s == 0) ? b.low : b.high;
            if (!done && !(s == 0 && pc[2]) && is_back_branch(w)) begin
                b.next_pc = base + ((s == 0) ? 32'd0 : 32'd4) + br_off(w);
                if (s == 0) b.high_live = 1'b0;
                done = 1'b1;
            end
        end
        return b;
    endfunction

    // ---------------- static predictor model -------------------------------
    always_comb begin
        pred_take   = 1'b0;
        pred_target = 32'h0;
        pred_skip_b = 1'b0;
        if (!pred_pc2 && is_back_branch(pred_instr_low)) begin
            pred_take   = 1'b1;
            pred_target = pred_pc + br_off(pred_instr_low);
            pred_skip_b = 1'b1;
        end else if (is_back_branch(pred_instr_high)) begin
            pred_take   = 1'b1;
            pred_target = pred_pc + 32'd4 + br_off(pred_instr_high);
        end
    end

    // ---------------- monitor / scoreboard ---------------------------------
    initial begin
        int      idle;
        bundle_t e;
        idle = 0;
        forever begin
            @(negedge clk);
            if (scoreboard_on) begin
                if (redirect_valid) begin
                    check("redirect_gates_out_valid", out_valid, 0);
                    idle = 0;
                end else if (out_valid && out_ready) begin
                    check("scoreboard_depth", exp_q.size(), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("bundle_pc", out_pc, e.pc);
                        check("bundle_low", out_instr_low, e.low);
                        check("bundle_high", out_instr_high, e.high);
                        check("bundle_low_valid", out_low_valid, e.low_live);
                        check("bundle_high_valid", out_high_valid, e.high_live);
                        exp_q.push_back(ref_bundle(e.next_pc));
                    end
                    accepts++;
                    idle = 0;
                end else begin
                    if (out_valid) check("stall_blocks_req", mem_req, 0);
                    idle++;
                    if (idle == 64) check("cycles_without_progress", idle, 0);
                end
            end
        end
    end

    // ---------------- global time limit ------------------------------------
    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "time limit");
    end

    // ---------------- stimulus ---------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic respond(input logic [63:0] data);
        mem_ready = 1'b1;
        mem_rdata = data;
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] snap_pc;
        logic [31:0] snap_lo;
        logic [31:0] snap_hi;
        int          lat;

        rst            = 1'b1;
        mem_ready      = 1'b0;
        mem_rdata      = 64'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        lat            = 0;

        // Reset state
        tick();
        tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_low_valid", out_low_valid, 0);
        check("rst_high_valid", out_high_valid, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_buffer", {out_instr_high, out_instr_low}, 0);
        rst = 1'b0;
        #1 check("deassert_cycle_mem_req", mem_req, 0);
        tick();
        check("first_req", mem_req, 1);
        check("first_addr", mem_addr, 32'h1000);

        // Sequential fetch
        respond({NOP, NOP});
        check("seq_valid", out_valid, 1);
        check("seq_pc", out_pc, 32'h1000);
        check("seq_slots", {out_low_valid, out_high_valid}, 2'b11);
        check("hold_no_req", mem_req, 0);
        accept();
        check("seq_next_addr", mem_addr, 32'h1008);
        check("seq_next_req", mem_req, 1);

        // Reset mid-fetch with a coincident response that must be ignored
        rst       = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        check("midrst_req", mem_req, 0);
        check("midrst_valid", out_valid, 0);
        rst       = 1'b0;
        mem_ready = 1'b0;
        tick();
        check("midrst_restart_addr", mem_addr, 32'h1000);
        check("midrst_restart_req", mem_req, 1);
        check("midrst_no_bundle", out_valid, 0);

        // Slot0 backward branch (-32)
        respond({NOP, make_br(32'hFFFF_FFE0)});
        check("br0_valid", out_valid, 1);
        check("br0_slots", {out_low_valid, out_high_valid}, 2'b10);
        check("br0_pred_low", pred_instr_low, make_br(32'hFFFF_FFE0));
        accept();
        check("br0_target_addr", mem_addr, 32'h0FE0);

        // Redirect coincident with the response: data dropped
        mem_ready      = 1'b1;
        mem_rdata      = {NOP, NOP};
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1000;
        tick();
        mem_ready      = 1'b0;
        redirect_valid = 1'b0;
        check("coinc_no_bundle", out_valid, 0);
        check("coinc_req", mem_req, 1);
        check("coinc_addr", mem_addr, 32'h1000);

        // Slot1 backward branch (-8) to 0x0FFC
        respond({make_br(32'hFFFF_FFF8), NOP});
        check("br1_valid", out_valid, 1);
        check("br1_slots", {out_low_valid, out_high_valid}, 2'b11);
        accept();
        check("br1_target_addr", mem_addr, 32'h0FF8);
        respond({NOP, NOP});
        check("br1_pred_pc2", pred_pc2, 1);
        check("br1_slots_after", {out_low_valid, out_high_valid}, 2'b01);
        check("br1_bundle_pc", out_pc, 32'h0FF8);
        accept();
        check("br1_seq_addr", mem_addr, 32'h1000);

        // Redirect to 0x2006 while the fetch waits: drain stale response
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2006;
        tick();
        redirect_valid = 1'b0;
        check("drain_req", mem_req, 1);
        tick();
        tick();
        check("drain_still_req", mem_req, 1);
        respond(64'hBAD0_BAD0_BAD0_BAD0);
        check("drain_no_bundle", out_valid, 0);
        check("drain_new_addr", mem_addr, 32'h2000);
        check("drain_new_req", mem_req, 1);
        respond({32'h0000_0093, NOP});
        check("drain_bundle_valid", out_valid, 1);
        check("drain_bundle_pc", out_pc, 32'h2000);
        check("drain_slots", {out_low_valid, out_high_valid}, 2'b01);
        check("drain_bundle_data", {out_instr_high, out_instr_low}, {32'h0000_0093, NOP});

        // Backpressure for 5 cycles, then redirect from HOLD
        snap_pc = out_pc;
        snap_lo = out_instr_low;
        snap_hi = out_instr_high;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_req", mem_req, 0);
            check("bp_stable", {out_pc, out_instr_low, out_instr_high}, {snap_pc, snap_lo, snap_hi});
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000;
        #1 check("hold_redirect_gate", out_valid, 0);
        tick();
        redirect_valid = 1'b0;
        check("hold_redirect_addr", mem_addr, 32'h3000);
        check("hold_redirect_req", mem_req, 1);

        // Sequential wrap from 0xFFFF_FFF8
        respond({NOP, NOP});
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        check("wrap_start_addr", mem_addr, 32'hFFFF_FFF8);
        respond({NOP, NOP});
        accept();
        check("wrap_addr", mem_addr, 32'h0000_0000);

        // Randomized phase: memory with random latency, random redirects and
        // random decode backpressure.
        scoreboard_on = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            mem_ready = 1'b0;
            if (mem_req) begin
                if (lat == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = {mem_word(mem_addr + 32'd4), mem_word(mem_addr)};
                    lat       = $urandom_range(0, 3);
                end else begin
                    lat--;
                end
            end
            redirect_valid = (cyc == 0) || ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            if (redirect_valid) begin
                exp_q.delete();
                exp_q.push_back(ref_bundle(redirect_pc & ~32'h3));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        scoreboard_on  = 1'b0;
        mem_ready      = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        tick();
        check("random_phase_accepts", accepts >= 100, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Front-end fetch controller for the dual-slot pipeline. It owns the fetch PC and issues 64-bit fetch requests to instruction memory, one outstanding at a time. Each returned doubleword is held in a one-entry bundle buffer, and the buffer drives the static branch predictor combinationally. The block then hands the decode stage a bundle of up to two instructions with per-slot valid bits, and picks the next fetch PC from three sources: sequential, predicted-taken target, or an execute-stage redirect.

## Interface
- RESET_PC, 32'h0000_0000: first fetch PC after reset; bits [1:0] must be 0.

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_req  out  1  fetch request; held high until mem_ready
- mem_addr  out  32  doubleword-aligned fetch address, {pc[31:3],3'b000}
- mem_ready  in  1  response strobe; mem_rdata valid this cycle; may coincide with the request's first cycle
- mem_rdata  in  64  [31:0] = slot0 (low word), [63:32] = slot1 (high word)
- pred_instr_low  out  32  buffered slot0 word, to predictor
- pred_instr_high  out  32  buffered slot1 word, to predictor
- pred_pc  out  32  buffered bundle base, {bpc[31:3],3'b000}
- pred_pc2  out  1  bpc[2]; 1 means slot0 is not part of the bundle
- pred_take  in  1  predictor: a valid slot holds a backward branch
- pred_target  in  32  predictor branch target
- pred_skip_b  in  1  predictor: slot0 branch taken, so slot1 is dead
- redirect_valid  in  1  execute-stage mispredict/jump correction
- redirect_pc  in  32  corrected PC; bits [1:0] ignored (forced 0)
- out_valid  out  1  bundle available to decode
- out_ready  in  1  decode accepts the bundle
- out_pc  out  32  bundle base address ({bpc[31:3],3'b000})
- out_instr_low  out  32  slot0 instruction
- out_instr_high  out  32  slot1 instruction
- out_low_valid  out  1  slot0 is architecturally live
- out_high_valid  out  1  slot1 is architecturally live

## Operation
- Registers:
  - pc: next fetch PC.
  - bpc: PC of the buffered bundle.
  - buf_low, buf_high: buffered slot words.
  - state: one of FETCH, HOLD, DRAIN.
- FETCH:
  - mem_req=1, mem_addr from pc.
  - On mem_ready: latch mem_rdata into the buffer, bpc<=pc, go to HOLD.
- HOLD:
  - Buffer drives the pred_* outputs.
  - out_valid = !redirect_valid.
  - out_low_valid = !bpc[2].
  - out_high_valid = !(pred_take && pred_skip_b).
  - On out_valid && out_ready: pc <= pred_take ? pred_target : {bpc[31:3],3'b000}+8; go to FETCH.
- DRAIN:
  - The request is still outstanding but its data is stale. mem_req stays 1.
  - On mem_ready: discard data, go to FETCH with the current pc.
- Redirect has the highest priority. In every state it sets pc <= {redirect_pc[31:2],2'b00}, and its state effect depends on where the block is:
  - FETCH without mem_ready: go to DRAIN; the request cannot be aborted.
  - FETCH with mem_ready in the same cycle: discard data, stay in FETCH.
  - HOLD: drop the bundle, go to FETCH. out_valid is already gated low this cycle.
  - DRAIN: update pc, stay in DRAIN.
- Predictor use:
  - With bpc[2]=1, slot0 is ignored by the predictor and marked invalid here.
  - A slot1 taken branch keeps both slots valid.
- Arithmetic is 32-bit and wraps modulo 2^32; sequential from 0xFFFF_FFF8 goes to 0x0000_0000.

## Timing
- Reset values (during rst and the cycle it deasserts):
  - state=FETCH, pc=RESET_PC, buffer=0, bpc=0.
  - mem_req=0, out_valid=0, out_low_valid=0, out_high_valid=0.
  - mem_req rises the first cycle after rst is sampled low.
- rst mid-request: any in-flight mem_ready response is ignored for the rst cycle, and fetching restarts at RESET_PC. The memory side must tolerate this abort.
- Latency:
  - mem_ready in cycle N → out_valid in N+1.
  - Accept in cycle M → mem_req for the next PC in M+1.
  - No overlap: one outstanding request and one buffer entry.
- While out_valid=1 and out_ready=0: all out_* and pred_* are stable and mem_req=0.
- redirect_valid → mem_addr shows the new PC in the next cycle if no request is outstanding. Otherwise it shows one cycle after the draining mem_ready.
- out_valid depends combinationally on redirect_valid. There is no other input-to-output combinational path besides pred_* → out_high_valid.

## Test plan
- Reset and sequential fetch: RESET_PC=0x1000; after rst, mem_addr=0x1000; respond NOP,NOP → out_pc=0x1000, both slots valid; after accept, mem_addr=0x1008.
- Slot0 backward branch (-32) at 0x1000: predictor reports take=1, target=0x0FE0, skip=1 → out_low_valid=1, out_high_valid=0, next mem_addr=0x0FE0.
- Slot1 branch (-8) at 0x1000: target=0x0FFC → both slots valid; next mem_addr=0x0FF8, pred_pc2=1, next bundle has only out_high_valid=1.
- Redirect to 0x2006 while a fetch waits 3 cycles for mem_ready → DRAIN, the returned data never appears on out_*, next mem_addr=0x2000, bundle low invalid (pc[2]=1).
- Backpressure: out_ready=0 for 5 cycles → out_* stable and mem_req=0. Then redirect to 0x3000 in HOLD → out_valid=0 the same cycle, next mem_addr=0x3000.
- Corner cases:
  - redirect_valid coincident with mem_ready → data discarded, next mem_addr is the redirect.
  - rst asserted mid-fetch → mem_req=0, then restart at RESET_PC.
  - Sequential fetch from 0xFFFF_FFF8 → next mem_addr wraps to 0x0.
